// File: rtl/if_id_stage_if.sv
// Bus bundle between fetch, the IF/ID register and decode.
// The stage itself takes the slave view; the fetch/decode environment takes the master view.
interface if_id_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_instr;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [31:0]     id_instr;

  modport master (
    output flush, if_valid, if_pc, if_instr, id_ready,
    input  if_ready, id_valid, id_pc, id_pc_plus4, id_instr
  );

  modport slave (
    input  flush, if_valid, if_pc, if_instr, id_ready,
    output if_ready, id_valid, id_pc, id_pc_plus4, id_instr
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer (main + skid).
// if_ready comes straight from a flop, so decode stalls never reach fetch combinationally.
// The main register always holds the oldest beat and drives the decode outputs.
module if_id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_stage_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic            if_ready_reg;
  logic            if_ready_next;
  logic [XLEN-1:0] main_pc_reg;
  logic [31:0]     main_instr_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic [31:0]     skid_instr_reg;

  logic            id_valid_w;
  logic            in_fire;
  logic            out_fire;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;

  assign id_valid_w = (state_reg != ST_EMPTY);
  assign in_fire    = bus.if_valid & if_ready_reg;
  assign out_fire   = id_valid_w & bus.id_ready;

  // Next-state and register-load selection; flush wins over every handshake.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = ST_FULL;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // if_ready is low here, so only the drain side can move.
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_next     = ST_ONE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
    if_ready_next = (state_next != ST_FULL);
  end

  // Occupancy state and the registered ready toward fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      if_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      if_ready_reg <= if_ready_next;
    end
  end

  // Main register: takes the incoming beat directly or the promoted skid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc_reg    <= '0;
      main_instr_reg <= NOP_INSTR;
    end else if (load_main_in) begin
      main_pc_reg    <= bus.if_pc;
      main_instr_reg <= bus.if_instr;
    end else if (load_main_skid) begin
      main_pc_reg    <= skid_pc_reg;
      main_instr_reg <= skid_instr_reg;
    end
  end

  // Skid register: catches the beat accepted while decode is stalled on the main beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc_reg    <= '0;
      skid_instr_reg <= NOP_INSTR;
    end else if (load_skid) begin
      skid_pc_reg    <= bus.if_pc;
      skid_instr_reg <= bus.if_instr;
    end
  end

  // Decode-side outputs are forced to a bubble whenever no beat is held, hiding stale data.
  assign bus.if_ready    = if_ready_reg;
  assign bus.id_valid    = id_valid_w;
  assign bus.id_pc       = id_valid_w ? main_pc_reg : '0;
  assign bus.id_pc_plus4 = id_valid_w ? (main_pc_reg + XLEN'(4)) : '0;
  assign bus.id_instr    = id_valid_w ? main_instr_reg : NOP_INSTR;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: the reference model is a plain 2-deep FIFO of beats.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  if_id_stage_if #(.XLEN(32)) bus ();

  if_id_stage #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: beats held by the stage, oldest first, at most two.
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  // Beats the fetch side still wants to deliver.
  logic [31:0] src_pc[$];
  logic [31:0] src_in[$];

  logic [97:0] obs;
  logic [97:0] exp_vec;
  assign obs = {bus.id_valid, bus.if_ready, bus.id_pc, bus.id_pc_plus4, bus.id_instr};

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return (pc << 5) ^ 32'h00500093;
  endfunction

  task automatic model_expect();
    logic        v;
    logic        r;
    logic [31:0] p;
    logic [31:0] p4;
    logic [31:0] ins;
    v = (q_pc.size() > 0);
    r = (q_pc.size() < 2);
    p = 32'h0; p4 = 32'h0; ins = NOP;
    if (v) begin
      p   = q_pc[0];
      p4  = q_pc[0] + 32'd4;
      ins = q_in[0];
    end
    exp_vec = {v, r, p, p4, ins};
  endtask

  task automatic offer();
    if (src_pc.size() > 0) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = src_pc[0];
      bus.if_instr = src_in[0];
    end else begin
      bus.if_valid = 1'b0;
      bus.if_pc    = 32'h0;
      bus.if_instr = 32'h0;
    end
  endtask

  task automatic add_src(input logic [31:0] pc);
    src_pc.push_back(pc);
    src_in.push_back(mk_instr(pc));
  endtask

  // One clock: advance the model from the inputs present before the edge.
  task automatic tick(output bit accepted);
    bit          fl;
    bit          of;
    bit          inf;
    logic [31:0] pc;
    logic [31:0] ins;
    fl  = bus.flush;
    of  = !fl && (q_pc.size() > 0) && bus.id_ready;
    inf = !fl && bus.if_valid && (q_pc.size() < 2);
    pc  = bus.if_pc;
    ins = bus.if_instr;
    @(posedge clk);
    if (fl) begin
      q_pc.delete();
      q_in.delete();
    end else begin
      if (of) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (inf) begin
        q_pc.push_back(pc);
        q_in.push_back(ins);
      end
    end
    #1;
    accepted = inf;
  endtask

  task automatic step();
    bit acc;
    tick(acc);
    if (acc) begin
      void'(src_pc.pop_front());
      void'(src_in.pop_front());
    end
  endtask

  task automatic test_reset();
    bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0; bus.id_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    checks++;
    if (bus.if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", bus.if_ready); end
    checks++;
    if (bus.id_instr !== NOP) begin failures++; $display("FAIL reset_id_instr got=%h exp=%h", bus.id_instr, NOP); end
    checks++;
    if (bus.id_pc !== 32'h0 || bus.id_pc_plus4 !== 32'h0) begin
      failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", bus.id_pc, bus.id_pc_plus4);
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_stream();
    logic [31:0] seen[$];
    for (int i = 0; i < 4; i++) add_src(32'(i * 4));
    bus.id_ready = 1;
    for (int c = 0; c < 7; c++) begin
      offer();
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL stream cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bus.id_valid && bus.id_ready) seen.push_back(bus.id_pc);
      step();
    end
    checks++;
    if (seen.size() != 4) begin
      failures++; $display("FAIL stream_count got=%0d exp=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== 32'(i * 4)) begin failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, seen[i], 32'(i * 4)); end
      end
    end
    $display("test_stream done checks=%0d", checks);
  endtask

  task automatic test_stall();
    logic [31:0] seen[$];
    add_src(32'h100); add_src(32'h104); add_src(32'h108);
    bus.id_ready = 0;
    for (int c = 0; c < 3; c++) begin
      offer();
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL stall cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      step();
    end
    offer();
    checks++;
    if (bus.id_pc !== 32'h100 || bus.if_ready !== 1'b0 || bus.id_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got pc=%h rdy=%b v=%b exp pc=00000100 rdy=0 v=1", bus.id_pc, bus.if_ready, bus.id_valid);
    end
    bus.id_ready = 1;
    for (int c = 0; c < 6; c++) begin
      offer();
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL stall_release cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bus.id_valid) seen.push_back(bus.id_pc);
      step();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'h100 || seen[1] !== 32'h104 || seen[2] !== 32'h108) begin
      failures++; $display("FAIL stall_order got=%p exp=256,260,264", seen);
    end
    $display("test_stall done checks=%0d", checks);
  endtask

  task automatic test_flush();
    add_src(32'h300); add_src(32'h304);
    bus.id_ready = 0;
    for (int c = 0; c < 3; c++) begin
      offer();
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL flush_fill cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      step();
    end
    // Redirect while full, with a new beat offered the same cycle.
    bus.flush = 1; bus.if_valid = 1; bus.if_pc = 32'h200; bus.if_instr = mk_instr(32'h200);
    step();
    bus.flush = 0; bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== NOP || bus.if_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_full got v=%b ins=%h rdy=%b exp v=0 ins=%h rdy=1", bus.id_valid, bus.id_instr, bus.if_ready, NOP);
    end
    bus.id_ready = 1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL flush_no_beat cyc=%0d got v=%b pc=%h exp v=0", c, bus.id_valid, bus.id_pc); end
      step();
    end
    // Redirect while one beat is held and if_ready is high.
    add_src(32'h400);
    offer();
    step();
    bus.flush = 1; bus.if_valid = 1; bus.if_pc = 32'h404; bus.if_instr = mk_instr(32'h404);
    step();
    bus.flush = 0; bus.if_valid = 0;
    for (int c = 0; c < 2; c++) begin
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL flush_one cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      step();
    end
    $display("test_flush done checks=%0d", checks);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 11; i++) add_src(32'h500 + 32'(i * 4));
    bus.id_ready = 1;
    for (int c = 0; c < 12; c++) begin
      offer();
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL b2b cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (c >= 1 && c <= 10) begin
        checks++;
        if (bus.id_valid !== 1'b1 || bus.if_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_one cyc=%0d got v=%b rdy=%b exp v=1 rdy=1", c, bus.id_valid, bus.if_ready);
        end
      end
      step();
    end
    $display("test_back_to_back done checks=%0d", checks);
  endtask

  task automatic test_wrap();
    add_src(32'hFFFFFFFC);
    bus.id_ready = 0;
    offer();
    step();
    offer();
    checks++;
    if (bus.id_pc !== 32'hFFFFFFFC || bus.id_pc_plus4 !== 32'h00000000) begin
      failures++; $display("FAIL wrap got pc=%h p4=%h exp pc=fffffffc p4=00000000", bus.id_pc, bus.id_pc_plus4);
    end
    bus.id_ready = 1;
    step();
    model_expect();
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", obs, exp_vec); end
    $display("test_wrap done checks=%0d", checks);
  endtask

  task automatic test_reset_mid();
    add_src(32'h600); add_src(32'h604); add_src(32'h608);
    bus.id_ready = 0;
    for (int c = 0; c < 3; c++) begin
      offer();
      step();
    end
    offer();
    rst_n = 0;
    #1;
    checks++;
    if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1 || bus.id_instr !== NOP || bus.id_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid got v=%b rdy=%b ins=%h pc=%h exp v=0 rdy=1 ins=%h pc=0",
               bus.id_valid, bus.if_ready, bus.id_instr, bus.id_pc, NOP);
    end
    q_pc.delete(); q_in.delete(); src_pc.delete(); src_in.delete();
    bus.if_valid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    model_expect();
    checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL reset_mid_after got=%h exp=%h", obs, exp_vec); end
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  task automatic test_random();
    bit acc;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          have;
    have = 0; pc = 0; ins = 0;
    for (int c = 0; c < 400; c++) begin
      if (!have) begin
        pc   = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
        ins  = $urandom;
        have = 1;
      end
      bus.if_valid = ($urandom_range(0, 9) < 7);
      bus.if_pc    = pc;
      bus.if_instr = ins;
      bus.id_ready = ($urandom_range(0, 9) < 6);
      bus.flush    = ($urandom_range(0, 19) == 0);
      model_expect();
      checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, exp_vec); end
      if (bus.flush && bus.if_valid) have = 0;
      tick(acc);
      if (acc) have = 0;
    end
    bus.flush = 0; bus.if_valid = 0;
    $display("test_random done checks=%0d", checks);
  endtask

  initial begin
    clk = 0;
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
